core_io_hub: RTL and testbench

Parametrised I/O hub between the sample stream and an N-core processor array. It replaces per-core ad-hoc input fetch and output logging.
- Input side: holds one input sample and advances it whenever any core requests.
- Output side: captures each core's result on out_en, arbitrates round-robin among pending cores, and streams core-tagged results through a FIFO.
- Sits directly between the multicore array and the stream source/sink.

---
 rtl/core_io_hub_pkg.sv | 15 +
 rtl/core_io_hub_if.sv | 27 ++
 rtl/core_io_hub_fifo.sv | 46 ++++
 rtl/core_io_hub.sv | 153 +++++++++++++++
 tb/tb_core_io_hub.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_io_hub_pkg.sv
// Shared constants and helpers for the core I/O hub: request code, default widths,
// counter width and the core-tag width rule.
package core_io_pkg;

    localparam logic [3:0] REQ_CODE  = 4'd1;
    localparam int         IN_W_DEF  = 19;
    localparam int         OUT_W_DEF = 28;
    localparam int         CNT_W     = 16;

    // A single core still needs a one-bit tag.
    function automatic int tag_w(input int n_cores);
        return (n_cores <= 1) ? 1 : $clog2(n_cores);
    endfunction

endpackage

// File: rtl/core_io_hub_if.sv
// Stream-side bundle of the hub: upstream sample handshake and downstream
// tagged-result handshake. The hub uses the slave view, the stream environment the master view.
interface core_io_hub_if
    import core_io_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TAG_W = 6
);
    logic [IN_W-1:0]  s_data;
    logic             s_valid;
    logic             s_ready;
    logic [OUT_W-1:0] m_data;
    logic [TAG_W-1:0] m_tag;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_tag, m_valid
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_tag, m_valid
    );
endinterface

// File: rtl/core_io_hub_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; the head reads as zero when empty.
// Push is refused when full and pop is ignored when empty.
module hub_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // NOTE: storage has no reset; count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/core_io_hub.sv
// I/O hub between the sample stream and an N-core array: one shared held input
// sample, per-core result capture, round-robin arbitration into a tagged output FIFO.
module core_io_hub
    import core_io_pkg::*;
#(
    parameter int N_CORES    = 51,
    parameter int IN_W       = IN_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    core_io_hub_if.slave             bus,
    output logic [IN_W-1:0]          in,
    input  logic [4*N_CORES-1:0]     req_in,
    output logic                     in_take,
    input  logic [OUT_W*N_CORES-1:0] io_out,
    input  logic [4*N_CORES-1:0]     out_en,
    output logic [CNT_W-1:0]         starve_cnt,
    output logic [CNT_W-1:0]         overrun_cnt,
    output logic                     overrun
);
    localparam int TAG_W  = tag_w(N_CORES);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int FW     = TAG_W + OUT_W;
    localparam int DROP_W = $clog2(N_CORES + 1);

    // ---------------- input path ----------------
    logic hval;
    logic any_req;
    logic consume;
    logic load;

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        any_req = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            any_req = any_req | (req_in[4*i +: 4] == REQ_CODE);
        end
    end

    assign bus.s_ready = !hval || any_req;
    assign consume     = any_req && hval;
    assign load        = bus.s_valid && bus.s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            in         <= '0;
            hval       <= 1'b0;
            in_take    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            in_take <= consume;
            if (load) begin
                in   <= bus.s_data;
                hval <= 1'b1;
            end else if (consume) begin
                hval <= 1'b0;
            end
            if (any_req && !hval && (starve_cnt != '1)) starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // ---------------- capture and arbitration ----------------
    logic [N_CORES-1:0] pv;
    logic [OUT_W-1:0]   pd [N_CORES];
    logic [N_CORES-1:0] en;
    logic [N_CORES-1:0] cap;
    logic [N_CORES-1:0] gnt_vec;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   grant;
    logic               grant_vld;
    logic [CW-1:0]      fifo_count;
    logic [DROP_W-1:0]  drops;
    logic [CNT_W:0]     ov_sum;
    logic [FW-1:0]      fifo_head;

    // Scan starts at rr_ptr and wraps at N_CORES, not at the tag's power of two.
    always_comb begin
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        gnt_vec   = '0;
        idx       = 0;
        if (fifo_count < CW'(FIFO_DEPTH)) begin
            for (int k = 0; k < N_CORES; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_CORES) idx = idx - N_CORES;
                if (!grant_vld && pv[idx]) begin
                    grant_vld    = 1'b1;
                    grant        = TAG_W'(idx);
                    gnt_vec[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drops = '0;
        for (int i = 0; i < N_CORES; i++) begin
            en[i]  = (out_en[4*i +: 4] == REQ_CODE);
            cap[i] = en[i] && (!pv[i] || gnt_vec[i]);
            if (en[i] && pv[i] && !gnt_vec[i]) drops = drops + DROP_W'(1);
        end
    end

    assign ov_sum = {1'b0, overrun_cnt} + (CNT_W+1)'(drops);

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (cap[i]) pd[i] <= io_out[OUT_W*i +: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv          <= '0;
            rr_ptr      <= '0;
            overrun_cnt <= '0;
            overrun     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (cap[i])          pv[i] <= 1'b1;
                else if (gnt_vec[i]) pv[i] <= 1'b0;
            end
            if (grant_vld) begin
                rr_ptr <= (grant == TAG_W'(N_CORES - 1)) ? '0 : grant + TAG_W'(1);
            end
            if (drops != '0) begin
                overrun     <= 1'b1;
                overrun_cnt <= ov_sum[CNT_W] ? '1 : ov_sum[CNT_W-1:0];
            end
        end
    end

    // ---------------- output FIFO ----------------
    hub_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant_vld),
        .push_data({grant, pd[grant]}),
        .pop      (bus.m_valid && bus.m_ready),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign bus.m_valid             = (fifo_count != '0);
    assign {bus.m_tag, bus.m_data} = fifo_head;

endmodule

// File: tb/tb_core_io_hub.sv
// Self-checking bench for core_io_hub: input-path vector table, hand-written
// capture/arbitration/FIFO sequences, and randomized traffic against a queue-based model.
module tb_core_io_hub;
    import core_io_pkg::*;

    localparam int N     = 51;
    localparam int IW    = 19;
    localparam int OW    = 28;
    localparam int DEPTH = 16;
    localparam int TW    = tag_w(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_io_hub_if #(.IN_W(IW), .OUT_W(OW), .TAG_W(TW)) bus ();

    logic [IW-1:0]   in_bus;
    logic [4*N-1:0]  req_in;
    logic            in_take;
    logic [OW*N-1:0] io_out;
    logic [4*N-1:0]  out_en;
    logic [15:0]     starve_cnt;
    logic [15:0]     overrun_cnt;
    logic            overrun;

    core_io_hub #(
        .N_CORES(N), .IN_W(IW), .OUT_W(OW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .in         (in_bus),
        .req_in     (req_in),
        .in_take    (in_take),
        .io_out     (io_out),
        .out_en     (out_en),
        .starve_cnt (starve_cnt),
        .overrun_cnt(overrun_cnt),
        .overrun    (overrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] od(input int v);
        return OW'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        req_in      = '0;
        out_en      = '0;
        io_out      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            tag;
        logic [OW-1:0] d;
    } ent_t;

    logic [IW-1:0] md_in;
    bit            md_hval;
    bit            md_take;
    int            md_starve;
    int            md_ovcnt;
    bit            md_over;
    bit            md_pv [N];
    logic [OW-1:0] md_pd [N];
    int            md_rr;
    ent_t          md_q [$];

    task automatic model_reset();
        md_in = '0; md_hval = 0; md_take = 0; md_starve = 0;
        md_ovcnt = 0; md_over = 0; md_rr = 0;
        md_q.delete();
        for (int i = 0; i < N; i++) begin
            md_pv[i] = 0;
            md_pd[i] = '0;
        end
    endtask

    function automatic bit model_any();
        for (int i = 0; i < N; i++) if (req_in[4*i +: 4] == 4'd1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit   any;
        bit   rdy;
        bit   pop;
        int   g;
        ent_t e;
        any = model_any();
        rdy = !md_hval || any;
        pop = (md_q.size() > 0) && bus.m_ready;
        g   = -1;
        if (md_q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && md_pv[(md_rr + k) % N]) g = (md_rr + k) % N;
            end
        end
        if (g >= 0) begin
            e.tag = g;
            e.d   = md_pd[g];
            md_pv[g] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (out_en[4*i +: 4] == 4'd1) begin
                if (!md_pv[i]) begin
                    md_pd[i] = io_out[OW*i +: OW];
                    md_pv[i] = 1;
                end else begin
                    md_ovcnt = (md_ovcnt < 65535) ? md_ovcnt + 1 : 65535;
                    md_over  = 1;
                end
            end
        end
        if (pop) void'(md_q.pop_front());
        if (g >= 0) begin
            md_q.push_back(e);
            md_rr = (g + 1) % N;
        end
        md_take = any && md_hval;
        if (any && !md_hval) md_starve = (md_starve < 65535) ? md_starve + 1 : 65535;
        if (any) md_hval = 0;
        if (bus.s_valid && rdy) begin
            md_in   = bus.s_data;
            md_hval = 1;
        end
    endtask

    // ---------------- input-path vector table ----------------
    typedef struct {
        bit            rst;
        bit            sv;
        logic [IW-1:0] sd;
        int            ra;
        int            rb;
        logic [3:0]    rv;
        bit            e_rdy;
        logic [IW-1:0] e_in;
        bit            e_take;
        logic [15:0]   e_starve;
    } vec_t;

    vec_t tbl [12];

    initial begin
        rst = 1'b1;
        clear_inputs();

        tbl[0]  = '{0, 0, IW'(0),       0,  -1, 4'd1, 1, IW'(0),       0, 16'd1};
        tbl[1]  = '{0, 0, IW'(0),       0,  -1, 4'd1, 1, IW'(0),       0, 16'd2};
        tbl[2]  = '{0, 0, IW'(0),       0,  -1, 4'd1, 1, IW'(0),       0, 16'd3};
        tbl[3]  = '{1, 0, IW'(0),       -1, -1, 4'd1, 1, IW'(0),       0, 16'd0};
        tbl[4]  = '{0, 1, IW'(-5),      -1, -1, 4'd1, 1, IW'(-5),      0, 16'd0};
        tbl[5]  = '{0, 1, IW'(77),      -1, -1, 4'd1, 0, IW'(-5),      0, 16'd0};
        tbl[6]  = '{0, 1, IW'(77),      3,  -1, 4'd1, 1, IW'(77),      1, 16'd0};
        tbl[7]  = '{0, 0, IW'(0),       -1, -1, 4'd1, 0, IW'(77),      0, 16'd0};
        tbl[8]  = '{0, 0, IW'(0),       10, 20, 4'd1, 1, IW'(77),      1, 16'd0};
        tbl[9]  = '{0, 0, IW'(0),       5,  -1, 4'd1, 1, IW'(77),      0, 16'd1};
        tbl[10] = '{0, 0, IW'(0),       5,  -1, 4'd2, 1, IW'(77),      0, 16'd1};
        tbl[11] = '{0, 1, IW'(-262144), -1, -1, 4'd1, 1, IW'(-262144), 0, 16'd1};

        do_reset();
        check("reset_in", in_bus, 0);
        check("reset_take", in_take, 0);
        check("reset_m_valid", bus.m_valid, 0);
        check("reset_m_data", bus.m_data, 0);
        check("reset_m_tag", bus.m_tag, 0);
        check("reset_s_ready", bus.s_ready, 1);
        check("reset_counters", {starve_cnt, overrun_cnt, 15'd0, overrun}, 0);

        for (int k = 0; k < 12; k++) begin
            rst         = tbl[k].rst;
            bus.s_valid = tbl[k].sv;
            bus.s_data  = tbl[k].sd;
            req_in      = '0;
            if (tbl[k].ra >= 0) req_in[4*tbl[k].ra +: 4] = tbl[k].rv;
            if (tbl[k].rb >= 0) req_in[4*tbl[k].rb +: 4] = tbl[k].rv;
            #1;
            check($sformatf("tbl%0d_s_ready", k), bus.s_ready, tbl[k].e_rdy);
            step();
            check($sformatf("tbl%0d_in", k), in_bus, tbl[k].e_in);
            check($sformatf("tbl%0d_take", k), in_take, tbl[k].e_take);
            check($sformatf("tbl%0d_starve", k), starve_cnt, tbl[k].e_starve);
        end
        rst = 1'b0;

        // ---- three simultaneous results stream out in index order ----
        do_reset();
        bus.m_ready = 1'b1;
        out_en[4*2 +: 4]  = 4'd1; io_out[OW*2 +: OW]  = od(100);
        out_en[4*7 +: 4]  = 4'd1; io_out[OW*7 +: OW]  = od(-200);
        out_en[4*50 +: 4] = 4'd1; io_out[OW*50 +: OW] = od(300);
        step();
        out_en = '0;
        check("lat_m_valid_early", bus.m_valid, 0);
        step();
        check("seq_valid0", bus.m_valid, 1);
        check("seq_tag0", bus.m_tag, 2);
        check("seq_data0", bus.m_data, od(100));
        step();
        check("seq_tag1", bus.m_tag, 7);
        check("seq_data1", bus.m_data, od(-200));
        step();
        check("seq_tag2", bus.m_tag, 50);
        check("seq_data2", bus.m_data, od(300));
        step();
        check("seq_empty", bus.m_valid, 0);

        // ---- one core floods a stalled FIFO ----
        do_reset();
        for (int k = 0; k < 20; k++) begin
            out_en[4*1 +: 4]  = 4'd1;
            io_out[OW*1 +: OW] = od(1000 + k);
            step();
        end
        out_en = '0;
        check("full_m_valid", bus.m_valid, 1);
        check("full_overrun_cnt", overrun_cnt, 3);
        check("full_overrun", overrun, 1);
        check("full_head_tag", bus.m_tag, 1);
        check("full_head_data", bus.m_data, od(1000));
        bus.m_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("drain_data%0d", k), bus.m_data, od(1000 + k));
            check($sformatf("drain_valid%0d", k), bus.m_valid, 1);
        end
        step();
        check("drain_empty", bus.m_valid, 0);

        // ---- round-robin wrap: rr_ptr at 5, cores 3 and 9 pending ----
        do_reset();
        bus.m_ready = 1'b1;
        out_en[4*4 +: 4] = 4'd1; io_out[OW*4 +: OW] = od(44);
        step();
        out_en = '0;
        out_en[4*3 +: 4] = 4'd1; io_out[OW*3 +: OW] = od(33);
        out_en[4*9 +: 4] = 4'd1; io_out[OW*9 +: OW] = od(99);
        step();
        out_en = '0;
        check("rr_tag4", bus.m_tag, 4);
        step();
        check("rr_tag9", bus.m_tag, 9);
        check("rr_data9", bus.m_data, od(99));
        step();
        check("rr_tag3", bus.m_tag, 3);
        check("rr_data3", bus.m_data, od(33));
        step();
        check("rr_empty", bus.m_valid, 0);

        // ---- reset while draining with pending slots and nonzero counters ----
        do_reset();
        for (int c = 0; c < 12; c++) begin
            out_en[4*c +: 4] = 4'd1;
            io_out[OW*c +: OW] = od(500 + c);
        end
        step();
        out_en = '0;
        out_en[4*11 +: 4] = 4'd1; io_out[OW*11 +: OW] = od(9999);
        req_in[3:0] = 4'd1;
        step();
        out_en = '0;
        for (int j = 0; j < 7; j++) begin
            req_in[3:0] = (j < 2) ? 4'd1 : 4'd0;
            step();
        end
        check("mid_m_valid", bus.m_valid, 1);
        check("mid_head_data", bus.m_data, od(500));
        check("mid_overrun_cnt", overrun_cnt, 1);
        check("mid_starve", starve_cnt, 3);
        bus.m_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_tag", bus.m_tag, 0);
        check("rst_counters", {starve_cnt, overrun_cnt}, 0);
        check("rst_overrun", overrun, 0);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_in", in_bus, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            check("rst_pending_clear", bus.m_valid, 0);
        end

        // ---- randomized traffic against the model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            rst         = (cyc == 1500);
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = IW'($urandom);
            bus.m_ready = ((cyc % 400) < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 99);
                req_in[4*i +: 4] = (r < 2) ? 4'd1 : ((r < 4) ? 4'($urandom) : 4'd0);
                r = $urandom_range(0, 99);
                out_en[4*i +: 4] = (r < 5) ? 4'd1 : ((r < 7) ? 4'($urandom) : 4'd0);
                io_out[OW*i +: OW] = OW'($urandom);
            end
            #1;
            check("rnd_s_ready", bus.s_ready, !md_hval || model_any());
            if (rst) model_reset();
            else     model_edge();
            step();
            check("rnd_in", in_bus, md_in);
            check("rnd_take", in_take, md_take);
            check("rnd_m_valid", bus.m_valid, md_q.size() != 0);
            check("rnd_m_tag", bus.m_tag, (md_q.size() != 0) ? md_q[0].tag : 0);
            check("rnd_m_data", bus.m_data, (md_q.size() != 0) ? md_q[0].d : '0);
            check("rnd_starve", starve_cnt, md_starve);
            check("rnd_overrun_cnt", overrun_cnt, md_ovcnt);
            check("rnd_overrun", overrun, md_over);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
